// File: rtl/qspi_seq_pkg.sv
// Shared types, timing constants and helpers for the QSPI transaction sequencer.
package qspi_seq_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_GAP   = 4;
  localparam int unsigned TMR_W    = 3;

  localparam logic [1:0] MODE_SPI  = 2'b00;
  localparam logic [1:0] MODE_DUAL = 2'b01;
  localparam logic [1:0] MODE_QUAD = 2'b10;

  typedef enum logic [1:0] {
    PH_CMD,
    PH_ADDR,
    PH_DUMMY,
    PH_DATA
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Latched copy of one bus-side transaction request.
  typedef struct packed {
    logic [7:0]        cmd;
    logic [1:0]        cmd_mode;
    logic [DATA_W-1:0] addr;
    logic [2:0]        addr_bytes;
    logic [1:0]        addr_mode;
    logic [4:0]        dummy;
    logic [2:0]        data_bytes;
    logic [1:0]        data_mode;
    logic              read;
    logic [DATA_W-1:0] wdata;
  } xfer_req_t;

  // Fields presented to the shift kernel for one operation.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [1:0]        mode;
    logic              read;
  } kop_t;

  // Any mode with bit 1 set is quad; the kernel only understands 00/01/10.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    if (m[1]) return MODE_QUAD;
    return m;
  endfunction

  // Kernel cycle count: a first op from idle counts bits, chained ops count SCLKs.
  function automatic logic [CNT_W-1:0] cyc_cnt(input logic [5:0] bits,
                                               input logic [1:0] mode,
                                               input logic       first);
    logic [5:0] sclk;
    if (first)        sclk = bits;
    else if (mode[1]) sclk = bits >> 2;
    else if (mode[0]) sclk = bits >> 1;
    else              sclk = bits;
    return CNT_W'(sclk - 6'd1);
  endfunction

endpackage

// File: rtl/qspi_phase_sel.sv
// Phase skip/next logic and per-phase kernel field formatting.
module qspi_phase_sel
  import qspi_seq_pkg::*;
(
  input  xfer_req_t         req,
  input  phase_e            cur_phase,
  input  phase_e            fmt_phase,
  output phase_e            next_phase,
  output logic              is_last,
  output kop_t              op,
  output logic [DATA_W-1:0] rdata_mask
);

  logic [2:0] addr_bytes;
  logic [2:0] data_bytes;
  logic       has_addr;
  logic       has_dummy;
  logic       has_data;
  logic [5:0] addr_bits;
  logic [5:0] data_bits;
  logic [5:0] addr_shift;
  logic [5:0] data_shift;
  logic [1:0] mode;

  // Normalise byte counts: illegal address widths mean no address, data clamps at 4.
  always_comb begin
    addr_bytes = ((req.addr_bytes == 3'd3) || (req.addr_bytes == 3'd4)) ? req.addr_bytes : 3'd0;
    data_bytes = (req.data_bytes > 3'd4) ? 3'd4 : req.data_bytes;
    has_addr   = (addr_bytes != 3'd0);
    has_dummy  = (req.dummy != 5'd0);
    has_data   = (data_bytes != 3'd0);
    addr_bits  = 6'(addr_bytes) << 3;
    data_bits  = 6'(data_bytes) << 3;
    addr_shift = 6'd32 - addr_bits;
    data_shift = 6'd32 - data_bits;
  end

  // First enabled phase after the current one; none left means current is last.
  always_comb begin
    next_phase = cur_phase;
    is_last    = 1'b1;
    case (cur_phase)
      PH_CMD: begin
        if (has_addr) begin
          next_phase = PH_ADDR;
          is_last    = 1'b0;
        end else if (has_dummy) begin
          next_phase = PH_DUMMY;
          is_last    = 1'b0;
        end else if (has_data) begin
          next_phase = PH_DATA;
          is_last    = 1'b0;
        end
      end
      PH_ADDR: begin
        if (has_dummy) begin
          next_phase = PH_DUMMY;
          is_last    = 1'b0;
        end else if (has_data) begin
          next_phase = PH_DATA;
          is_last    = 1'b0;
        end
      end
      PH_DUMMY: begin
        if (has_data) begin
          next_phase = PH_DATA;
          is_last    = 1'b0;
        end
      end
      default: begin
        next_phase = cur_phase;
        is_last    = 1'b1;
      end
    endcase
  end

  // Kernel fields for the phase about to be presented, plus the read-data mask.
  always_comb begin
    op   = '0;
    mode = MODE_SPI;
    case (fmt_phase)
      PH_CMD: begin
        mode         = norm_mode(req.cmd_mode);
        op.data      = {req.cmd, 24'h0};
        op.mode      = mode;
        op.cycle_cnt = cyc_cnt(6'd8, mode, 1'b1);
        op.read      = 1'b0;
      end
      PH_ADDR: begin
        mode         = norm_mode(req.addr_mode);
        op.data      = req.addr << addr_shift;
        op.mode      = mode;
        op.cycle_cnt = cyc_cnt(addr_bits, mode, 1'b0);
        op.read      = 1'b0;
      end
      PH_DUMMY: begin
        op.data      = '0;
        op.mode      = MODE_SPI;
        op.cycle_cnt = cyc_cnt(6'(req.dummy), MODE_SPI, 1'b0);
        op.read      = 1'b1;
      end
      default: begin
        mode         = norm_mode(req.data_mode);
        op.data      = req.wdata << data_shift;
        op.mode      = mode;
        op.cycle_cnt = cyc_cnt(data_bits, mode, 1'b0);
        op.read      = req.read;
      end
    endcase
    rdata_mask = (req.read && has_data) ? (32'hFFFF_FFFF >> data_shift) : '0;
  end

endmodule

// File: rtl/qspi_xfer_seq.sv
// QSPI transaction sequencer: chip-select framing and kernel op chaining.
module qspi_xfer_seq
  import qspi_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_cmd,
  input  logic [1:0]        req_cmd_mode,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [2:0]        req_addr_bytes,
  input  logic [1:0]        req_addr_mode,
  input  logic [4:0]        req_dummy,
  input  logic [2:0]        req_data_bytes,
  input  logic [1:0]        req_data_mode,
  input  logic              req_read,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cs_n,
  output logic [DATA_W-1:0] k_data_input,
  output logic [CNT_W-1:0]  k_cycle_cnt,
  output logic [1:0]        k_mode_sel,
  output logic              k_op_read,
  output logic              k_op_valid,
  input  logic              k_load_flag,
  input  logic              k_op_end,
  input  logic [DATA_W-1:0] k_data_out,
  input  logic              k_dataout_valid
);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
  // The IDLE handshake cycle is the final high cycle of the gap.
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 2);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  phase_e            next_phase;
  xfer_req_t         req_q, req_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  kop_t              kop_q, kop_d;
  kop_t              op;
  logic              is_last;
  logic [DATA_W-1:0] rdata_mask;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              busy_d;
  logic              cs_n_d;
  logic              k_op_valid_d;

  qspi_phase_sel u_phase_sel (
    .req        (req_q),
    .cur_phase  (phase_q),
    .fmt_phase  (phase_d),
    .next_phase (next_phase),
    .is_last    (is_last),
    .op         (op),
    .rdata_mask (rdata_mask)
  );

  // Phase register advance: restart at CMD when idle, step on each kernel capture.
  always_comb begin
    phase_d = phase_q;
    if (state_q == ST_IDLE) begin
      phase_d = PH_CMD;
    end else if ((state_q == ST_RUN) && k_load_flag && !is_last) begin
      phase_d = next_phase;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    tmr_d        = tmr_q;
    kop_d        = kop_q;
    cs_n_d       = cs_n;
    k_op_valid_d = k_op_valid;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_d.cmd        = req_cmd;
          req_d.cmd_mode   = req_cmd_mode;
          req_d.addr       = req_addr;
          req_d.addr_bytes = req_addr_bytes;
          req_d.addr_mode  = req_addr_mode;
          req_d.dummy      = req_dummy;
          req_d.data_bytes = req_data_bytes;
          req_d.data_mode  = req_data_mode;
          req_d.read       = req_read;
          req_d.wdata      = req_wdata;
          tmr_d            = '0;
          cs_n_d           = 1'b0;
          state_d          = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // The command op starts a fresh chain, so the kernel must be idle first.
        if ((tmr_q == SETUP_LAST) && k_op_end) begin
          tmr_d        = '0;
          k_op_valid_d = 1'b1;
          state_d      = ST_RUN;
        end else if (tmr_q != SETUP_LAST) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (k_load_flag && is_last) begin
          k_op_valid_d = 1'b0;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (k_dataout_valid) begin
          rsp_rdata_d = k_data_out & rdata_mask;
          tmr_d       = '0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_d       = '0;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_GAP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cs_n_d       = 1'b1;
        k_op_valid_d = 1'b0;
      end
    endcase
    if (state_d == ST_RUN) kop_d = op;
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_CMD;
      req_q      <= '0;
      tmr_q      <= '0;
      kop_q      <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
      cs_n       <= 1'b1;
      k_op_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      req_q      <= req_d;
      tmr_q      <= tmr_d;
      kop_q      <= kop_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      busy       <= busy_d;
      cs_n       <= cs_n_d;
      k_op_valid <= k_op_valid_d;
    end
  end

  assign k_data_input = kop_q.data;
  assign k_cycle_cnt  = kop_q.cycle_cnt;
  assign k_mode_sel   = kop_q.mode;
  assign k_op_read    = kop_q.read;

endmodule

// File: tb/tb_qspi_xfer_seq.sv
// Directed self-checking bench for qspi_xfer_seq; the bench plays the shift kernel.
module tb_qspi_xfer_seq;
  import qspi_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd;
  logic [1:0]  req_cmd_mode, req_addr_mode, req_data_mode;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_addr_bytes, req_data_bytes;
  logic [4:0]  req_dummy;
  logic        req_read;
  logic        rsp_valid, busy, cs_n;
  logic [31:0] rsp_rdata;
  logic [31:0] k_data_input;
  logic [4:0]  k_cycle_cnt;
  logic [1:0]  k_mode_sel;
  logic        k_op_read, k_op_valid;
  logic        k_load_flag, k_op_end, k_dataout_valid;
  logic [31:0] k_data_out;

  always #5 clk = ~clk;

  qspi_xfer_seq dut (
    .clk(clk), .rst_ni(rst_ni),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_cmd_mode(req_cmd_mode),
    .req_addr(req_addr), .req_addr_bytes(req_addr_bytes), .req_addr_mode(req_addr_mode),
    .req_dummy(req_dummy), .req_data_bytes(req_data_bytes), .req_data_mode(req_data_mode),
    .req_read(req_read), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .cs_n(cs_n),
    .k_data_input(k_data_input), .k_cycle_cnt(k_cycle_cnt), .k_mode_sel(k_mode_sel),
    .k_op_read(k_op_read), .k_op_valid(k_op_valid),
    .k_load_flag(k_load_flag), .k_op_end(k_op_end),
    .k_data_out(k_data_out), .k_dataout_valid(k_dataout_valid)
  );

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  logic [31:0] od [8];
  logic [4:0]  oc [8];
  logic [1:0]  om [8];
  logic        orr[8];
  int          nops, setup_n, hold_n, gap_n, rsp_cnt;
  logic [31:0] got_rdata;
  logic        stable_ok, drain_ok;

  // Handshake sanity that must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (req_ready && busy) viol++;
      if (!cs_n && !busy) viol++;
      if (k_op_valid && cs_n) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [7:0] cmd, input logic [1:0] cmode,
                         input logic [31:0] addr, input logic [2:0] ab, input logic [1:0] amode,
                         input logic [4:0] dummy, input logic [2:0] db, input logic [1:0] dmode,
                         input logic rd, input logic [31:0] wdata);
    req_cmd = cmd; req_cmd_mode = cmode;
    req_addr = addr; req_addr_bytes = ab; req_addr_mode = amode;
    req_dummy = dummy; req_data_bytes = db; req_data_mode = dmode;
    req_read = rd; req_wdata = wdata;
  endtask

  // Runs one transaction as the kernel, recording every op and the CS framing.
  task automatic run_xfer(input int lat, input bit hold_valid, input bit pre_started,
                          input bit stray, input logic [31:0] ret);
    int n;
    nops = 0; setup_n = 0; hold_n = 0; gap_n = 0; rsp_cnt = 0;
    got_rdata = 32'h5A5A_5A5A; stable_ok = 1'b1; drain_ok = 1'b1;
    if (!pre_started) begin
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    if (!hold_valid) req_valid = 1'b0;
    n = 0;
    while (!k_op_valid && n < 20) begin
      k_load_flag = stray;
      @(negedge clk); n++;
    end
    k_load_flag = 1'b0;
    setup_n = n;
    n = 0;
    while (k_op_valid && nops < 8 && n < 100) begin
      od[nops] = k_data_input; oc[nops] = k_cycle_cnt;
      om[nops] = k_mode_sel;   orr[nops] = k_op_read;
      for (int w = 0; w < lat; w++) begin
        @(negedge clk); n++;
        if (!k_op_valid || k_data_input !== od[nops] || k_cycle_cnt !== oc[nops] ||
            k_mode_sel !== om[nops] || k_op_read !== orr[nops]) stable_ok = 1'b0;
      end
      k_load_flag = 1'b1; k_op_end = 1'b0;
      @(negedge clk); n++;
      k_load_flag = 1'b0;
      nops++;
    end
    for (int w = 0; w < 3; w++) begin
      if (rsp_valid || cs_n || k_op_valid) drain_ok = 1'b0;
      @(negedge clk);
    end
    k_data_out = ret; k_dataout_valid = 1'b1;
    @(negedge clk);
    k_dataout_valid = 1'b0; k_data_out = 32'h0; k_op_end = 1'b1;
    n = 0;
    while (!cs_n && n < 20) begin
      if (rsp_valid) drain_ok = 1'b0;
      @(negedge clk); n++;
    end
    hold_n = n;
    n = 0;
    while (cs_n && n < 20 && (hold_valid || n < int'(CS_GAP))) begin
      if (rsp_valid) begin rsp_cnt++; got_rdata = rsp_rdata; end
      @(negedge clk); n++;
    end
    gap_n = n;
  endtask

  initial begin
    int n;
    req_valid = 1'b0;
    set_req(8'h00, 2'b00, 32'h0, 3'd0, 2'b00, 5'd0, 3'd0, 2'b00, 1'b0, 32'h0);
    k_load_flag = 1'b0; k_op_end = 1'b1; k_data_out = 32'h0; k_dataout_valid = 1'b0;

    // Reset values
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_k_op_valid", 32'(k_op_valid), 32'd0);
    chk("rst_k_data", k_data_input, 32'd0);
    chk("rst_k_cnt", 32'(k_cycle_cnt), 32'd0);
    @(negedge clk); rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // T1: bare command 0x06
    set_req(8'h06, 2'b00, 32'h0, 3'd0, 2'b00, 5'd0, 3'd0, 2'b00, 1'b0, 32'h0);
    run_xfer(0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("t1_setup", 32'(setup_n), 32'd2);
    chk("t1_nops", 32'(nops), 32'd1);
    chk("t1_op0_data", od[0], 32'h0600_0000);
    chk("t1_op0_cnt", 32'(oc[0]), 32'd7);
    chk("t1_op0_mode", 32'(om[0]), 32'd0);
    chk("t1_op0_read", 32'(orr[0]), 32'd0);
    chk("t1_drain", 32'(drain_ok), 32'd1);
    chk("t1_hold", 32'(hold_n), 32'd2);
    chk("t1_rsp", 32'(rsp_cnt), 32'd1);
    chk("t1_rdata", got_rdata, 32'h0);
    chk("t1_idle_ready", 32'(req_ready), 32'd1);

    // T2: single read 0x03, 3-byte address, 4 data bytes
    set_req(8'h03, 2'b00, 32'h0012_3456, 3'd3, 2'b00, 5'd0, 3'd4, 2'b00, 1'b1, 32'h0);
    run_xfer(1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("t2_nops", 32'(nops), 32'd3);
    chk("t2_op0_data", od[0], 32'h0300_0000);
    chk("t2_op1_data", od[1], 32'h1234_5600);
    chk("t2_op1_cnt", 32'(oc[1]), 32'd23);
    chk("t2_op1_read", 32'(orr[1]), 32'd0);
    chk("t2_op2_cnt", 32'(oc[2]), 32'd31);
    chk("t2_op2_read", 32'(orr[2]), 32'd1);
    chk("t2_stable", 32'(stable_ok), 32'd1);
    chk("t2_rdata", got_rdata, 32'hDEAD_BEEF);

    // T3: quad read 0xEB with dummy; stray load pulses during setup are ignored
    set_req(8'hEB, 2'b00, 32'h00AB_CDEF, 3'd3, 2'b10, 5'd6, 3'd2, 2'b11, 1'b1, 32'h0);
    run_xfer(2, 1'b0, 1'b0, 1'b1, 32'h1234_A5C3);
    chk("t3_setup", 32'(setup_n), 32'd2);
    chk("t3_nops", 32'(nops), 32'd4);
    chk("t3_op0_data", od[0], 32'hEB00_0000);
    chk("t3_op1_data", od[1], 32'hABCD_EF00);
    chk("t3_op1_cnt", 32'(oc[1]), 32'd5);
    chk("t3_op1_mode", 32'(om[1]), 32'd2);
    chk("t3_op2_data", od[2], 32'h0);
    chk("t3_op2_cnt", 32'(oc[2]), 32'd5);
    chk("t3_op2_mode", 32'(om[2]), 32'd0);
    chk("t3_op2_read", 32'(orr[2]), 32'd1);
    chk("t3_op3_cnt", 32'(oc[3]), 32'd3);
    chk("t3_op3_mode", 32'(om[3]), 32'd2);
    chk("t3_stable", 32'(stable_ok), 32'd1);
    chk("t3_rdata", got_rdata, 32'h0000_A5C3);

    // T4: write 0x02, 4-byte address, 1 data byte
    set_req(8'h02, 2'b00, 32'h89AB_CDEF, 3'd4, 2'b00, 5'd0, 3'd1, 2'b00, 1'b0, 32'hAABB_CC7E);
    run_xfer(0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    chk("t4_nops", 32'(nops), 32'd3);
    chk("t4_op1_data", od[1], 32'h89AB_CDEF);
    chk("t4_op1_cnt", 32'(oc[1]), 32'd31);
    chk("t4_op2_data", od[2], 32'h7E00_0000);
    chk("t4_op2_cnt", 32'(oc[2]), 32'd7);
    chk("t4_op2_read", 32'(orr[2]), 32'd0);
    chk("t4_rdata", got_rdata, 32'h0);

    // T5: illegal addr width skips ADDR, oversize data clamps to 4, dual data, quad cmd
    set_req(8'h3B, 2'b10, 32'hFFFF_FFFF, 3'd2, 2'b00, 5'd0, 3'd7, 2'b01, 1'b1, 32'h1122_3344);
    run_xfer(0, 1'b0, 1'b0, 1'b0, 32'h0102_0304);
    chk("t5_nops", 32'(nops), 32'd2);
    chk("t5_op0_cnt", 32'(oc[0]), 32'd7);
    chk("t5_op0_mode", 32'(om[0]), 32'd2);
    chk("t5_op1_data", od[1], 32'h1122_3344);
    chk("t5_op1_cnt", 32'(oc[1]), 32'd15);
    chk("t5_op1_mode", 32'(om[1]), 32'd1);
    chk("t5_rdata", got_rdata, 32'h0102_0304);

    // T6: reset while the address op is presented
    set_req(8'h03, 2'b00, 32'h0012_3456, 3'd3, 2'b00, 5'd0, 3'd4, 2'b00, 1'b1, 32'h0);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!k_op_valid && n < 20) begin @(negedge clk); n++; end
    k_load_flag = 1'b1; k_op_end = 1'b0;
    @(negedge clk);
    k_load_flag = 1'b0;
    chk("t6_addr_presented", k_data_input, 32'h1234_5600);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_cs_n", 32'(cs_n), 32'd1);
    chk("t6_rst_op_valid", 32'(k_op_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    k_op_end = 1'b1;
    @(negedge clk); rst_ni = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", 32'(req_ready), 32'd1);
    set_req(8'h06, 2'b00, 32'h0, 3'd0, 2'b00, 5'd0, 3'd0, 2'b00, 1'b0, 32'h0);
    run_xfer(0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_post_nops", 32'(nops), 32'd1);
    chk("t6_post_op0", od[0], 32'h0600_0000);
    chk("t6_post_rsp", 32'(rsp_cnt), 32'd1);

    // T7: req_valid held high across two transactions
    run_xfer(0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t7_gap", 32'(gap_n), 32'd4);
    chk("t7_first_rsp", 32'(rsp_cnt), 32'd1);
    run_xfer(0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("t7_second_setup", 32'(setup_n), 32'd2);
    chk("t7_second_nops", 32'(nops), 32'd1);
    chk("t7_second_rsp", 32'(rsp_cnt), 32'd1);

    chk("handshake_viol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qspi_xfer_seq.md
Name: qspi_xfer_seq

Overview:
- Transaction sequencer that sits directly upstream of the QSPI shift kernel.
- Accepts one flash transaction per request: command, optional address, optional dummy cycles and optional data of up to 4 bytes.
- Splits the transaction into back-to-back kernel operations and drives flash chip-select around them.
- Returns read data and a completion pulse to the bus-side controller.

Parameters:
- CS_SETUP, 2, clk cycles CS_N is low before the first kernel op is requested.
- CS_HOLD, 2, clk cycles CS_N stays low after the final op completes.
- CS_GAP, 4, minimum clk cycles CS_N stays high between transactions.

Ports:
- clk  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid  in  1  transaction request
- req_ready  out  1  high in IDLE only; handshake = req_valid & req_ready
- req_cmd  in  8  command opcode
- req_cmd_mode  in  2  lane mode: 00 single, 01 dual, 1x quad (same encoding for all mode fields)
- req_addr  in  32  address, right-justified
- req_addr_bytes  in  3  0, 3 or 4; other values are treated as 0
- req_addr_mode  in  2  address lane mode
- req_dummy  in  5  dummy SCLK cycles, 0 = no dummy phase
- req_data_bytes  in  3  0..4; values >4 are clamped to 4
- req_data_mode  in  2  data lane mode
- req_read  in  1  1 = data phase reads, 0 = data phase writes
- req_wdata  in  32  write data, right-justified, MSB sent first
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data, right-justified, unused upper bits zero
- busy  out  1  high in every state except IDLE
- cs_n  out  1  flash chip select, active low
- k_data_input  out  32  kernel shift data, left-aligned
- k_cycle_cnt  out  5  kernel cycle count
- k_mode_sel  out  2  kernel lane mode
- k_op_read  out  1  kernel read/hi-Z op
- k_op_valid  out  1  kernel op request
- k_load_flag  in  1  kernel has captured the presented fields this clock
- k_op_end  in  1  kernel idle
- k_data_out  in  32  kernel received word
- k_dataout_valid  in  1  kernel final-op completion

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, cs_n=1, k_op_valid=0, all other k_* outputs=0, state=IDLE.
- req_ready=1 from the first clock after reset release.
- States:
  - IDLE: on handshake, latch all req_* fields; cs_n<=0; go to SETUP.
  - SETUP: counts CS_SETUP cycles, then goes to RUN.
  - RUN: k_op_valid=1 with the current phase's fields presented. On k_load_flag, advance the phase register on the same edge so the next phase's fields are valid the following cycle. When the last phase is captured, k_op_valid<=0 and go to DRAIN.
  - DRAIN: wait for k_dataout_valid. Capture rsp_rdata = k_data_out masked to data_bytes*8 bits (masked to 0 for writes or when data_bytes=0). Go to HOLD.
  - HOLD: counts CS_HOLD cycles, then cs_n<=1, rsp_valid pulses 1 cycle, go to GAP.
  - GAP: counts CS_GAP cycles with cs_n high, then go to IDLE.
- Phase order is CMD, ADDR, DUMMY, DATA. Skip ADDR when addr_bytes=0, DUMMY when dummy=0, DATA when data_bytes=0. CMD is always issued.
- Per-phase kernel fields:
  - CMD: data={cmd,24'b0}, read=0.
  - ADDR: addr left-shifted by 8*(4-addr_bytes), read=0.
  - DUMMY: data=0, read=1, mode=00, bits=dummy.
  - DATA: wdata left-shifted by 8*(4-data_bytes), read=req_read.
- k_cycle_cnt: CMD (the op started from kernel idle) = bits-1. Chained ops = (bits>>mode)-1, i.e. SCLK cycles minus 1. Quad mode shifts by 2.
- The kernel returns received data only for the final op of a chain. Consequently read data is legal only in the DATA phase, which is always last.
- req_* inputs are ignored outside IDLE.
- rst_ni asserted mid-transaction: immediate return to reset values; cs_n=1 asynchronously.
- Protocol-error guard: k_load_flag outside RUN is ignored.

Decomposition:
- Package qspi_seq_pkg holds:
  - phase enum (PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA)
  - state enum
  - mode encodings MODE_SPI=2'b00, MODE_DUAL=2'b01, MODE_QUAD=2'b10
  - function cyc_cnt(bits, mode, first)
- One sub-module, qspi_phase_sel: combinational next-phase and skip logic plus field formatting. The FSM and counters stay in the top.

Test Plan:
- cmd=0x06, no addr/data, single mode -> one kernel op, data=0x06000000, cycle_cnt=7. cs_n low for SETUP+8 SCLK+HOLD. rsp_valid=1, rdata=0.
- Read 0x03, addr=0x123456 (3 bytes), 4 data bytes single, flash returns 0xDEADBEEF -> three ops: addr data=0x12345600 with cycle_cnt=23, data op cycle_cnt=31. rsp_rdata=0xDEADBEEF.
- Quad read 0xEB: addr quad, dummy=6, 2 data bytes quad, flash returns 0xA5C3 -> addr cycle_cnt=5, dummy cycle_cnt=5 mode=00 read=1, data cycle_cnt=3. rsp_rdata=0x0000A5C3.
- Write 0x02, addr 4 bytes, 1 byte wdata=0x7E -> data op data=0x7E000000, read=0. QOE active during data. rsp_rdata=0.
- rst_ni low during ADDR phase -> cs_n=1, k_op_valid=0 same cycle. After release, req_ready=1 and the next transaction completes normally.
- req_valid held high back-to-back -> cs_n high for exactly CS_GAP cycles between transactions; req_ready=0 throughout busy.
